bram_dp_param: RTL and testbench
================================

Name: bram_dp_param

Overview:
- Parametrised simple-dual-port block RAM; successor to the fixed 12-word, 32-bit, byte-write tap/data RAM used by the FIR datapath.
- Port A is read/write with byte enables. Port B is read-only, so a coefficient/data fetch can overlap an AXI-Lite or stream write.
- Adds the following over the fixed RAM: configurable width, depth and read latency; collision policy; registered outputs with valid strobes; out-of-range detection; optional hardware clear-on-reset sequencer.

Parameters:
- DATA_WIDTH, 32, word width in bits; must be a multiple of 8; NB = DATA_WIDTH/8 byte lanes.
- DEPTH, 12, number of words; any value 2..4096.
- ADDR_WIDTH, 12, byte-address width of A_A and A_B.
- READ_LATENCY, 1, cycles from accepted read to Do/VLD; legal values are 1 and 2.
- WRITE_MODE, 0, same-word read/write collision policy; 0 = read-first (old data), 1 = write-first (new byte-merged data).
- CLEAR_ON_RESET, 1, 1 = zero all words after reset via the sequencer; 0 = contents untouched.

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST  in  1  synchronous active-high reset.
- EN_A  in  1  port A access enable.
- WE_A  in  NB  port A byte write enables; bit i writes Di_A[8i+7:8i].
- A_A  in  ADDR_WIDTH  port A byte address; word index = A_A >> log2(NB).
- Di_A  in  DATA_WIDTH  port A write data.
- Do_A  out  DATA_WIDTH  port A registered read data.
- VLD_A  out  1  one-cycle strobe; Do_A holds the result of a port A read.
- EN_B  in  1  port B read enable.
- A_B  in  ADDR_WIDTH  port B byte address.
- Do_B  out  DATA_WIDTH  port B registered read data.
- VLD_B  out  1  one-cycle strobe; Do_B holds the result of a port B read.
- BUSY  out  1  clear sequencer active; all accesses ignored.
- ERR  out  1  sticky flag: an out-of-range access occurred.

Behaviour:

Reset:
- Do_A, Do_B, VLD_A, VLD_B, ERR = 0; read pipelines flushed.
- BUSY = CLEAR_ON_RESET; memory contents are not reset directly.

Sequencer states: IDLE, CLEAR.
- RST forces CLEAR (if CLEAR_ON_RESET=1) with clr_cnt = 0.
- In CLEAR with RST low: mem[clr_cnt] <= 0 and clr_cnt++ each cycle. At clr_cnt == DEPTH-1, the final word is written and the sequencer moves to IDLE.
- BUSY is high for exactly DEPTH cycles after RST falls. While RST is held, clr_cnt stays at 0.
- RST mid-clear restarts the sequence at word 0.

Accesses during BUSY or RST:
- EN_A and EN_B are ignored: no write, no VLD, ERR unchanged.

Access acceptance (IDLE only):
- A read is accepted on port A when EN_A=1 and WE_A==0, and on port B when EN_B=1.
- Port A with EN_A=1 and WE_A!=0 is a write. It produces no VLD_A unless WRITE_MODE=1, in which case VLD_A returns the merged word.

Writes:
- Byte-masked; unselected lanes keep their old value. Effective at the rising edge where EN_A is sampled.

Read latency:
- READ_LATENCY=1: Do/VLD update at the edge after the access is sampled.
- READ_LATENCY=2: one extra register stage; throughput stays one read per cycle per port.
- Do holds its last value when VLD=0.

Range check:
- A word index >= DEPTH means the access is out of range.
- An out-of-range write is dropped.
- An out-of-range read still strobes VLD, with Do = 0.
- ERR is set on the cycle after any out-of-range access and stays high until RST.

Collisions (B reads the word A writes in the same cycle, or A read with write under WRITE_MODE=1):
- WRITE_MODE=0: the read returns the pre-write word.
- WRITE_MODE=1: the read returns the post-write word with byte merge applied.

Address handling:
- Low log2(NB) address bits are ignored.
- Address bits above the index width participate in the range check; there is no wrap-around.

Test Plan:
1. Clear sequence (defaults): RST high 3 cycles then low. BUSY stays high 12 cycles then falls; B-port reads of words 0..11 then return 0x00000000 with VLD_B one cycle later. EN_A pulses during BUSY write nothing.
2. Byte write: write 0xDEADBEEF to A_A=0x008 with WE_A=4'hF, then 0x00000012 with WE_A=4'b0001. A read of 0x008 returns 0xDEADBE12 with VLD_A 1 cycle after the read.
3. Collision, WRITE_MODE=0 vs 1: word 3 holds 0x11111111. A writes 0x22222222 to 0x00C while B reads 0x00C in the same cycle. Do_B = 0x11111111 for mode 0 and 0x22222222 for mode 1; the next read returns 0x22222222 in both modes.
4. Out-of-range: write to 0x030 (word 12). The write is dropped, ERR rises the next cycle and remains high. A read of 0x030 gives VLD_B=1, Do_B=0. Word 0 is unchanged.
5. READ_LATENCY=2, DATA_WIDTH=64, DEPTH=16: back-to-back B reads of words 0..15 on consecutive cycles. VLD_B is high for 16 consecutive cycles, starting 2 cycles after the first read, with data in order.
6. Reset mid-clear: RST reasserted when clr_cnt=5. BUSY stays high; after release, a full DEPTH-cycle clear restarts, and ERR and VLD are 0 throughout.

Source files
------------

// File: rtl/bram_dp_param.sv
// Simple-dual-port block RAM: port A read/write with byte enables, port B read-only.
// Registered outputs with valid strobes, range checking and an optional clear-after-reset sweep.
module bram_dp_param #(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned DEPTH          = 12,
  parameter int unsigned ADDR_WIDTH     = 12,
  parameter int unsigned READ_LATENCY   = 1,
  parameter int unsigned WRITE_MODE     = 0,
  parameter int unsigned CLEAR_ON_RESET = 1
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic                    EN_A,
  input  logic [DATA_WIDTH/8-1:0] WE_A,
  input  logic [ADDR_WIDTH-1:0]   A_A,
  input  logic [DATA_WIDTH-1:0]   Di_A,
  output logic [DATA_WIDTH-1:0]   Do_A,
  output logic                    VLD_A,
  input  logic                    EN_B,
  input  logic [ADDR_WIDTH-1:0]   A_B,
  output logic [DATA_WIDTH-1:0]   Do_B,
  output logic                    VLD_B,
  output logic                    BUSY,
  output logic                    ERR
);

  localparam int unsigned NB  = DATA_WIDTH / 8;
  localparam int unsigned LSB = $clog2(NB);
  localparam int unsigned IW  = ADDR_WIDTH - LSB;
  localparam int unsigned MAW = $clog2(DEPTH);

  typedef enum logic [0:0] {StIdle, StClear} state_e;

  state_e         state_q, state_d;
  logic [MAW-1:0] clr_cnt_q, clr_cnt_d;
  logic           clr_we;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  // Clear sequencer
  always_comb begin
    state_d   = state_q;
    clr_cnt_d = clr_cnt_q;
    clr_we    = 1'b0;
    unique case (state_q)
      StClear: begin
        clr_we    = !RST;
        clr_cnt_d = clr_cnt_q + 1'b1;
        if (clr_cnt_q == MAW'(DEPTH - 1)) begin
          state_d   = StIdle;
          clr_cnt_d = '0;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= (CLEAR_ON_RESET != 0) ? StClear : StIdle;
      clr_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      clr_cnt_q <= clr_cnt_d;
    end
  end

  logic busy, accept;
  assign busy   = (state_q == StClear);
  assign accept = !RST && !busy;
  assign BUSY   = busy;

  // Address decode; upper bits take part in the range check so there is no aliasing.
  logic [IW-1:0]  wa_full, wb_full;
  logic [MAW-1:0] idx_a, idx_b;
  logic           oor_a, oor_b;

  assign wa_full = A_A[ADDR_WIDTH-1:LSB];
  assign wb_full = A_B[ADDR_WIDTH-1:LSB];
  assign oor_a   = (32'(wa_full) >= DEPTH);
  assign oor_b   = (32'(wb_full) >= DEPTH);
  assign idx_a   = MAW'(wa_full);
  assign idx_b   = MAW'(wb_full);

  if (LSB > 0) begin : g_lsb
    logic unused_lsb;
    assign unused_lsb = ^{A_A[LSB-1:0], A_B[LSB-1:0]};
  end

  logic                  wr_a, rd_a, rd_b, col_b, oor_hit;
  logic [DATA_WIDTH-1:0] rdata_a, rdata_b, merged_a, dat1_a, dat1_b;
  logic                  vld1_a;

  assign wr_a    = accept && EN_A && (|WE_A);
  assign rd_a    = accept && EN_A && !(|WE_A);
  assign rd_b    = accept && EN_B;
  assign rdata_a = oor_a ? '0 : mem[idx_a];
  assign rdata_b = oor_b ? '0 : mem[idx_b];
  assign oor_hit = accept && ((EN_A && oor_a) || (EN_B && oor_b));

  always_comb begin
    merged_a = rdata_a;
    for (int unsigned i = 0; i < NB; i++) begin
      if (WE_A[i]) merged_a[8*i +: 8] = Di_A[8*i +: 8];
    end
  end

  // Write-first returns the merged word; an out-of-range write reports zero.
  assign vld1_a = rd_a || (wr_a && (WRITE_MODE == 1));
  assign dat1_a = (rd_a || oor_a) ? rdata_a : merged_a;
  assign col_b  = wr_a && !oor_a && !oor_b && (idx_a == idx_b) && (WRITE_MODE == 1);
  assign dat1_b = col_b ? merged_a : rdata_b;

  always_ff @(posedge CLK) begin
    if (clr_we) begin
      mem[clr_cnt_q] <= '0;
    end else if (wr_a && !oor_a) begin
      mem[idx_a] <= merged_a;
    end
  end

  logic err_q;
  always_ff @(posedge CLK) begin
    if (RST)          err_q <= 1'b0;
    else if (oor_hit) err_q <= 1'b1;
  end
  assign ERR = err_q;

  // First output stage; data registers only load on a valid result.
  logic                  va_q, vb_q;
  logic [DATA_WIDTH-1:0] da_q, db_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      va_q <= 1'b0;
      vb_q <= 1'b0;
      da_q <= '0;
      db_q <= '0;
    end else begin
      va_q <= vld1_a;
      vb_q <= rd_b;
      if (vld1_a) da_q <= dat1_a;
      if (rd_b)   db_q <= dat1_b;
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic                  va2_q, vb2_q;
    logic [DATA_WIDTH-1:0] da2_q, db2_q;

    always_ff @(posedge CLK) begin
      if (RST) begin
        va2_q <= 1'b0;
        vb2_q <= 1'b0;
        da2_q <= '0;
        db2_q <= '0;
      end else begin
        va2_q <= va_q;
        vb2_q <= vb_q;
        if (va_q) da2_q <= da_q;
        if (vb_q) db2_q <= db_q;
      end
    end

    assign VLD_A = va2_q;
    assign VLD_B = vb2_q;
    assign Do_A  = da2_q;
    assign Do_B  = db2_q;
  end else begin : g_lat1
    assign VLD_A = va_q;
    assign VLD_B = vb_q;
    assign Do_A  = da_q;
    assign Do_B  = db_q;
  end

endmodule

// File: tb/tb_bram_dp_param.sv
// Bench for bram_dp_param: a default instance (32b x 12, latency 1, read-first) and a
// 64b x 16, latency 2, write-first instance, checked through per-port expectation queues.
module tb_bram_dp_param;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;
  logic RST;

  logic        en_a0, en_b0, vld_a0, vld_b0, busy0, err0;
  logic [3:0]  we_a0;
  logic [11:0] a_a0, a_b0;
  logic [31:0] di_a0, do_a0, do_b0;

  logic        en_a1, en_b1, vld_a1, vld_b1, busy1, err1;
  logic [7:0]  we_a1;
  logic [11:0] a_a1, a_b1;
  logic [63:0] di_a1, do_a1, do_b1;

  bram_dp_param dut0 (
    .CLK(CLK), .RST(RST), .EN_A(en_a0), .WE_A(we_a0), .A_A(a_a0), .Di_A(di_a0),
    .Do_A(do_a0), .VLD_A(vld_a0), .EN_B(en_b0), .A_B(a_b0), .Do_B(do_b0), .VLD_B(vld_b0),
    .BUSY(busy0), .ERR(err0)
  );

  bram_dp_param #(
    .DATA_WIDTH(64), .DEPTH(16), .ADDR_WIDTH(12), .READ_LATENCY(2), .WRITE_MODE(1),
    .CLEAR_ON_RESET(1)
  ) dut1 (
    .CLK(CLK), .RST(RST), .EN_A(en_a1), .WE_A(we_a1), .A_A(a_a1), .Di_A(di_a1),
    .Do_A(do_a1), .VLD_A(vld_a1), .EN_B(en_b1), .A_B(a_b1), .Do_B(do_b1), .VLD_B(vld_b1),
    .BUSY(busy1), .ERR(err1)
  );

  typedef struct {
    int          cyc;
    logic [63:0] data;
  } exp_t;

  typedef struct {
    logic        ea;
    logic [3:0]  we;
    logic [11:0] aa;
    logic [31:0] di;
    logic        eb;
    logic [11:0] ab;
    logic        va;
    logic [31:0] xa;
    logic        vb;
    logic [31:0] xb;
  } vec_t;

  exp_t qa0[$], qb0[$], qa1[$], qb1[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic sb(input string nm, input logic [63:0] act, input bit have, input exp_t e);
    n_cmp++;
    if (!have) begin
      n_bad++;
      $display("FAIL %s: unexpected valid at cycle %0d, data %h", nm, cyc, act);
    end else if (e.cyc != cyc || e.data !== act) begin
      n_bad++;
      $display("FAIL %s: got %h at cycle %0d, expected %h at cycle %0d",
               nm, act, cyc, e.data, e.cyc);
    end
  endtask

  always @(negedge CLK) begin : mon
    exp_t e;
    bit   h;
    if (vld_a0 === 1'b1) begin
      h = qa0.size() != 0;
      e = '{cyc: -1, data: '0};
      if (h) begin e = qa0[0]; void'(qa0.pop_front()); end
      sb("dut0_port_a", 64'(do_a0), h, e);
    end
    if (vld_b0 === 1'b1) begin
      h = qb0.size() != 0;
      e = '{cyc: -1, data: '0};
      if (h) begin e = qb0[0]; void'(qb0.pop_front()); end
      sb("dut0_port_b", 64'(do_b0), h, e);
    end
    if (vld_a1 === 1'b1) begin
      h = qa1.size() != 0;
      e = '{cyc: -1, data: '0};
      if (h) begin e = qa1[0]; void'(qa1.pop_front()); end
      sb("dut1_port_a", do_a1, h, e);
    end
    if (vld_b1 === 1'b1) begin
      h = qb1.size() != 0;
      e = '{cyc: -1, data: '0};
      if (h) begin e = qb1[0]; void'(qb1.pop_front()); end
      sb("dut1_port_b", do_b1, h, e);
    end
  end

  task automatic push(input int port, input int lat, input logic [63:0] d);
    exp_t e;
    e = '{cyc: cyc + lat, data: d};
    case (port)
      0:       qa0.push_back(e);
      1:       qb0.push_back(e);
      2:       qa1.push_back(e);
      default: qb1.push_back(e);
    endcase
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic drv0(input logic ea, input logic [3:0] we, input logic [11:0] aa,
                      input logic [31:0] di, input logic eb, input logic [11:0] ab);
    en_a0 = ea; we_a0 = we; a_a0 = aa; di_a0 = di; en_b0 = eb; a_b0 = ab;
  endtask

  task automatic drv1(input logic ea, input logic [7:0] we, input logic [11:0] aa,
                      input logic [63:0] di, input logic eb, input logic [11:0] ab);
    en_a1 = ea; we_a1 = we; a_a1 = aa; di_a1 = di; en_b1 = eb; a_b1 = ab;
  endtask

  function automatic logic [63:0] d1(input int i);
    return {32'hC0DE0000 | 32'(i), 32'(i) * 32'h01010101};
  endfunction

  // Clocks through a clear sweep, recording how many cycles each BUSY stays high.
  task automatic clear_wait(output int n0, output int n1, input bit poke);
    int n;
    n = 0; n0 = 0; n1 = 0;
    while ((busy0 || busy1) && n < 40) begin
      if (poke && n == 3) begin
        drv0(1'b1, 4'hF, 12'h000, 32'hFFFFFFFF, 1'b1, 12'h000);
        drv1(1'b1, 8'hFF, 12'h000, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 12'h000);
      end else if (poke && n == 5) begin
        drv0(1'b1, 4'h0, 12'h030, 32'h0, 1'b1, 12'h030);
        drv1(1'b0, 8'h00, 12'h000, 64'h0, 1'b1, 12'h080);
      end else begin
        drv0(1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 12'h000);
        drv1(1'b0, 8'h00, 12'h000, 64'h0, 1'b0, 12'h000);
      end
      tick();
      n++;
      if (!busy0 && n0 == 0) n0 = n;
      if (!busy1 && n1 == 0) n1 = n;
    end
    drv0(1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 12'h000);
    drv1(1'b0, 8'h00, 12'h000, 64'h0, 1'b0, 12'h000);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  vec_t tbl[9];

  initial begin : main
    int n0, n1;
    tbl[0] = '{1'b1, 4'hF, 12'h008, 32'hDEADBEEF, 1'b1, 12'h008, 1'b0, 32'h0, 1'b1, 32'h0};
    tbl[1] = '{1'b1, 4'h1, 12'h008, 32'h00000012, 1'b1, 12'h008, 1'b0, 32'h0, 1'b1, 32'hDEADBEEF};
    tbl[2] = '{1'b1, 4'h0, 12'h008, 32'h0, 1'b1, 12'h004, 1'b1, 32'hDEADBE12, 1'b1, 32'h0};
    tbl[3] = '{1'b1, 4'hF, 12'h00C, 32'h11111111, 1'b0, 12'h000, 1'b0, 32'h0, 1'b0, 32'h0};
    tbl[4] = '{1'b1, 4'hF, 12'h00C, 32'h22222222, 1'b1, 12'h00C, 1'b0, 32'h0, 1'b1, 32'h11111111};
    tbl[5] = '{1'b1, 4'h0, 12'h00C, 32'h0, 1'b1, 12'h00C, 1'b1, 32'h22222222, 1'b1, 32'h22222222};
    tbl[6] = '{1'b1, 4'hA, 12'h000, 32'hAABBCCDD, 1'b1, 12'h001, 1'b0, 32'h0, 1'b1, 32'h0};
    tbl[7] = '{1'b1, 4'h0, 12'h003, 32'h0, 1'b1, 12'h02C, 1'b1, 32'hAA00CC00, 1'b1, 32'h0};
    tbl[8] = '{1'b1, 4'hF, 12'h028, 32'h0BADF00D, 1'b1, 12'h028, 1'b0, 32'h0, 1'b1, 32'h0};

    RST = 1'b1;
    drv0(1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 12'h000);
    drv1(1'b0, 8'h00, 12'h000, 64'h0, 1'b0, 12'h000);
    tick();
    chk("rst_do_a0", 64'(do_a0), 64'h0);
    chk("rst_do_b0", 64'(do_b0), 64'h0);
    chk("rst_vld0", 64'({vld_a0, vld_b0}), 64'h0);
    chk("rst_err0", 64'(err0), 64'h0);
    chk("rst_busy0", 64'(busy0), 64'h1);
    chk("rst_do_b1", do_b1, 64'h0);
    chk("rst_busy1", 64'(busy1), 64'h1);
    tick();
    tick();
    RST = 1'b0;

    // Clear sweep with ignored accesses during BUSY
    clear_wait(n0, n1, 1'b1);
    chk("busy0_len", 64'(n0), 64'd12);
    chk("busy1_len", 64'(n1), 64'd16);
    chk("busy_err0", 64'(err0), 64'h0);
    chk("busy_err1", 64'(err1), 64'h0);

    for (int i = 0; i < 12; i++) begin
      drv0(1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 12'(i * 4));
      push(1, 1, 64'h0);
      tick();
    end

    for (int i = 0; i < 9; i++) begin
      drv0(tbl[i].ea, tbl[i].we, tbl[i].aa, tbl[i].di, tbl[i].eb, tbl[i].ab);
      if (tbl[i].va) push(0, 1, 64'(tbl[i].xa));
      if (tbl[i].vb) push(1, 1, 64'(tbl[i].xb));
      tick();
    end
    drv0(1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 12'h000);
    tick();

    // Out-of-range write to word 12, then out-of-range and high-address reads
    chk("err0_pre", 64'(err0), 64'h0);
    drv0(1'b1, 4'hF, 12'h030, 32'h55555555, 1'b0, 12'h000);
    tick();
    drv0(1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 12'h000);
    chk("err0_set", 64'(err0), 64'h1);
    tick();
    tick();
    chk("err0_sticky", 64'(err0), 64'h1);
    drv0(1'b1, 4'h0, 12'h030, 32'h0, 1'b1, 12'h030);
    push(0, 1, 64'h0);
    push(1, 1, 64'h0);
    tick();
    drv0(1'b1, 4'h0, 12'h000, 32'h0, 1'b1, 12'h800);
    push(0, 1, 64'hAA00CC00);
    push(1, 1, 64'h0);
    tick();
    drv0(1'b0, 4'h0, 12'h000, 32'h0, 1'b1, 12'h02C);
    push(1, 1, 64'h0);
    tick();
    drv0(1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 12'h000);
    tick();

    // Wide, two-stage, write-first instance
    drv1(1'b0, 8'h00, 12'h000, 64'h0, 1'b1, 12'h028);
    push(3, 2, 64'h0);
    tick();
    for (int i = 0; i < 16; i++) begin
      drv1(1'b1, 8'hFF, 12'(i * 8), d1(i), 1'b0, 12'h000);
      push(2, 2, d1(i));
      tick();
    end
    for (int i = 0; i < 16; i++) begin
      drv1(1'b0, 8'h00, 12'h000, 64'h0, 1'b1, 12'(i * 8));
      push(3, 2, d1(i));
      tick();
    end
    drv1(1'b1, 8'hFF, 12'h018, 64'h1111_1111_1111_1111, 1'b0, 12'h000);
    push(2, 2, 64'h1111_1111_1111_1111);
    tick();
    drv1(1'b1, 8'hFF, 12'h018, 64'h2222_2222_2222_2222, 1'b1, 12'h018);
    push(2, 2, 64'h2222_2222_2222_2222);
    push(3, 2, 64'h2222_2222_2222_2222);
    tick();
    drv1(1'b1, 8'h0F, 12'h018, 64'hFFFF_FFFF_AAAA_AAAA, 1'b1, 12'h018);
    push(2, 2, 64'h2222_2222_AAAA_AAAA);
    push(3, 2, 64'h2222_2222_AAAA_AAAA);
    tick();
    drv1(1'b0, 8'h00, 12'h000, 64'h0, 1'b1, 12'h018);
    push(3, 2, 64'h2222_2222_AAAA_AAAA);
    tick();
    chk("err1_pre", 64'(err1), 64'h0);
    drv1(1'b0, 8'h00, 12'h000, 64'h0, 1'b1, 12'h080);
    push(3, 2, 64'h0);
    tick();
    drv1(1'b0, 8'h00, 12'h000, 64'h0, 1'b0, 12'h000);
    chk("err1_set", 64'(err1), 64'h1);
    tick();
    tick();
    tick();

    // Reset reasserted after five words have been cleared
    RST = 1'b1;
    tick();
    chk("rst2_err0", 64'(err0), 64'h0);
    RST = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("midclr_busy0", 64'(busy0), 64'h1);
    RST = 1'b1;
    tick();
    tick();
    chk("midclr_rst_busy0", 64'(busy0), 64'h1);
    chk("midclr_rst_busy1", 64'(busy1), 64'h1);
    RST = 1'b0;
    clear_wait(n0, n1, 1'b1);
    chk("reclr_busy0_len", 64'(n0), 64'd12);
    chk("reclr_busy1_len", 64'(n1), 64'd16);
    chk("reclr_err0", 64'(err0), 64'h0);
    chk("reclr_err1", 64'(err1), 64'h0);

    drv0(1'b1, 4'h0, 12'h028, 32'h0, 1'b1, 12'h008);
    drv1(1'b1, 8'h00, 12'h078, 64'h0, 1'b1, 12'h000);
    push(0, 1, 64'h0);
    push(1, 1, 64'h0);
    push(2, 2, 64'h0);
    push(3, 2, 64'h0);
    tick();
    drv0(1'b0, 4'h0, 12'h000, 32'h0, 1'b0, 12'h000);
    drv1(1'b0, 8'h00, 12'h000, 64'h0, 1'b0, 12'h000);
    for (int k = 0; k < 4; k++) tick();

    chk("left_qa0", 64'(qa0.size()), 64'h0);
    chk("left_qb0", 64'(qb0.size()), 64'h0);
    chk("left_qa1", 64'(qa1.size()), 64'h0);
    chk("left_qb1", 64'(qb1.size()), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
